// File: rtl/control_pkg.sv
// control_pkg: state, opcode-class and control-field encodings shared by the control unit
package control_pkg;

    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_IR_LOAD, S_DECODE,
        S_EXEC_R, S_EXEC_I, S_WB_ALU,
        S_ADDR, S_MEM_RD, S_MEM_LATCH, S_WB_LD, S_MEM_WR,
        S_BRANCH, S_PC_INC, S_LUI, S_JAL1, S_JAL2,
        S_EXC_CAUSE, S_EXC_EPC, S_EXC_LATCH, S_EXC_JUMP, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_INV, OP_ADD, OP_SUB, OP_AND, OP_ADDI, OP_LD, OP_SD,
        OP_BEQ, OP_BNE, OP_LUI, OP_JAL, OP_EBREAK
    } opClass_t;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_ADDI = 7'b0010011;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_SD   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_SYS  = 7'b1110011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_SD  = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic       MUXA_PC   = 1'b0;
    localparam logic       MUXA_REGA = 1'b1;
    localparam logic [1:0] MUXB_REGB  = 2'b00;
    localparam logic [1:0] MUXB_FOUR  = 2'b01;
    localparam logic [1:0] MUXB_IMM   = 2'b10;
    localparam logic [1:0] MUXB_IMMSH = 2'b11;
    localparam logic [1:0] MUXPC_ALU    = 2'b00;
    localparam logic [1:0] MUXPC_ALUOUT = 2'b01;
    localparam logic [1:0] MUXPC_EXC    = 2'b10;
    localparam logic [2:0] MUXD_ALUOUT = 3'b000;
    localparam logic [2:0] MUXD_IMM    = 3'b001;
    localparam logic [2:0] MUXD_MDR    = 3'b010;
    localparam logic [2:0] MUXD_PC     = 3'b101;
    localparam logic [1:0] MUXM_ALUOUT  = 2'b00;
    localparam logic [1:0] MUXM_VEC_INV = 2'b01;
    localparam logic [1:0] MUXM_VEC_OVF = 2'b10;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [2:0] IMM_I  = 3'b000;
    localparam logic [2:0] IMM_S  = 3'b001;
    localparam logic [2:0] IMM_SB = 3'b010;
    localparam logic [2:0] IMM_U  = 3'b011;
    localparam logic [2:0] IMM_UJ = 3'b100;

    localparam logic [1:0] BRK_DWORD = 2'b00;
    localparam logic [1:0] BRK_BYTE  = 2'b11;

    localparam logic CAUSE_INVALID = 1'b0;
    localparam logic CAUSE_OVF     = 1'b1;

endpackage

// File: rtl/control_decode.sv
// control_decode: classifies the latched instruction into one supported operation
module control_decode
    import control_pkg::*;
(
    input  logic [31:0] complete_inst,
    output opClass_t    opClass,
    output logic        valid
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unusedFields;

    assign opcode = complete_inst[6:0];
    assign funct3 = complete_inst[14:12];
    assign funct7 = complete_inst[31:25];
    assign unusedFields = ^{complete_inst[24:15], complete_inst[11:7]};

    // opcode plus funct fields select the class; any other combination is invalid
    always_comb begin
        opClass = OP_INV;
        case (opcode)
            OPC_R:    opClass = (funct3 == F3_ADD && funct7 == F7_BASE) ? OP_ADD :
                                (funct3 == F3_ADD && funct7 == F7_SUB)  ? OP_SUB :
                                (funct3 == F3_AND && funct7 == F7_BASE) ? OP_AND : OP_INV;
            OPC_ADDI: opClass = (funct3 == F3_ADD) ? OP_ADDI : OP_INV;
            OPC_LD:   opClass = (funct3 == F3_LD) ? OP_LD : OP_INV;
            OPC_SD:   opClass = (funct3 == F3_SD) ? OP_SD : OP_INV;
            OPC_BR:   opClass = (funct3 == F3_BEQ) ? OP_BEQ : (funct3 == F3_BNE) ? OP_BNE : OP_INV;
            OPC_LUI:  opClass = OP_LUI;
            OPC_JAL:  opClass = OP_JAL;
            OPC_SYS:  opClass = OP_EBREAK;
            default:  opClass = OP_INV;
        endcase
    end

    assign valid = opClass != OP_INV;

endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle sequencer driving the RISC-V datapath strobes and selects
module control_unit
    import control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] complete_inst,
    input  logic        Igual,
    input  logic        Overflow,
    output logic        PcWr,
    output logic        InRegWr,
    output logic        RegAWr,
    output logic        RegBWr,
    output logic        AluOutWr,
    output logic        MdrWr,
    output logic        DtMemWr,
    output logic        BaRegWr,
    output logic        EpcWr,
    output logic        CaseWr,
    output logic        MuxAS,
    output logic [1:0]  MuxBS,
    output logic [1:0]  MuxPC,
    output logic [2:0]  MuxDS,
    output logic [1:0]  MuxDataMem,
    output logic [2:0]  AluOp,
    output logic [2:0]  immtype,
    output logic [1:0]  break_type,
    output logic [1:0]  break_mem_type,
    output logic [1:0]  ShiftOP,
    output logic [63:0] Case_Number,
    output logic        halted
);

    state_t     state, nextState;
    opClass_t   opClass;
    logic       valid;
    logic       cause;
    logic       pcInc;
    logic       ovfTrap;
    logic       taken;
    logic [1:0] vecSel;

    control_decode uDecode (
        .complete_inst(complete_inst),
        .opClass(opClass),
        .valid(valid)
    );

    assign ovfTrap = Overflow && (opClass == OP_ADD || opClass == OP_SUB || opClass == OP_ADDI);
    assign taken = (opClass == OP_BEQ && Igual) || (opClass == OP_BNE && !Igual);
    assign vecSel = (cause == CAUSE_OVF) ? MUXM_VEC_OVF : MUXM_VEC_INV;
    assign ShiftOP = 2'b00;

    // state register; the cause is captured on the edge that enters the trap sequence
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RESET;
            cause <= CAUSE_INVALID;
        end else begin
            state <= nextState;
            if (nextState == S_EXC_CAUSE)
                cause <= (state == S_DECODE) ? CAUSE_INVALID : CAUSE_OVF;
        end
    end

    // next state and Moore outputs, with Mealy branch/overflow decisions; all zero under rst
    always_comb begin
        PcWr = 1'b0;
        InRegWr = 1'b0;
        RegAWr = 1'b0;
        RegBWr = 1'b0;
        AluOutWr = 1'b0;
        MdrWr = 1'b0;
        DtMemWr = 1'b0;
        BaRegWr = 1'b0;
        EpcWr = 1'b0;
        CaseWr = 1'b0;
        MuxAS = MUXA_PC;
        MuxBS = MUXB_REGB;
        MuxPC = MUXPC_ALU;
        MuxDS = MUXD_ALUOUT;
        MuxDataMem = MUXM_ALUOUT;
        AluOp = ALU_PASS;
        immtype = IMM_I;
        break_type = BRK_DWORD;
        break_mem_type = BRK_DWORD;
        Case_Number = '0;
        halted = 1'b0;
        pcInc = 1'b0;
        nextState = state;
        if (!rst) begin
            case (state)
                S_RESET:   nextState = S_FETCH;
                S_FETCH:   nextState = S_IR_LOAD;
                S_IR_LOAD: begin
                    InRegWr = 1'b1;
                    nextState = S_DECODE;
                end
                S_DECODE: begin
                    RegAWr = 1'b1;
                    RegBWr = 1'b1;
                    AluOutWr = 1'b1;
                    MuxBS = MUXB_IMMSH;
                    AluOp = ALU_ADD;
                    immtype = (opClass == OP_JAL) ? IMM_UJ : IMM_SB;
                    if (!valid)
                        nextState = S_EXC_CAUSE;
                    else
                        case (opClass)
                            OP_ADD, OP_SUB, OP_AND: nextState = S_EXEC_R;
                            OP_ADDI:                nextState = S_EXEC_I;
                            OP_LD, OP_SD:           nextState = S_ADDR;
                            OP_BEQ, OP_BNE:         nextState = S_BRANCH;
                            OP_LUI:                 nextState = S_LUI;
                            OP_JAL:                 nextState = S_JAL1;
                            OP_EBREAK:              nextState = S_HALT;
                            default:                nextState = S_EXC_CAUSE;
                        endcase
                end
                S_EXEC_R: begin
                    MuxAS = MUXA_REGA;
                    AluOutWr = 1'b1;
                    AluOp = (opClass == OP_SUB) ? ALU_SUB : (opClass == OP_AND) ? ALU_AND : ALU_ADD;
                    nextState = ovfTrap ? S_EXC_CAUSE : S_WB_ALU;
                end
                S_EXEC_I: begin
                    MuxAS = MUXA_REGA;
                    MuxBS = MUXB_IMM;
                    AluOp = ALU_ADD;
                    AluOutWr = 1'b1;
                    nextState = ovfTrap ? S_EXC_CAUSE : S_WB_ALU;
                end
                S_WB_ALU: begin
                    BaRegWr = 1'b1;
                    pcInc = 1'b1;
                    nextState = S_FETCH;
                end
                S_ADDR: begin
                    MuxAS = MUXA_REGA;
                    MuxBS = MUXB_IMM;
                    AluOp = ALU_ADD;
                    AluOutWr = 1'b1;
                    immtype = (opClass == OP_SD) ? IMM_S : IMM_I;
                    nextState = (opClass == OP_SD) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD:  nextState = S_MEM_LATCH;
                S_MEM_LATCH: begin
                    MdrWr = 1'b1;
                    nextState = S_WB_LD;
                end
                S_WB_LD: begin
                    BaRegWr = 1'b1;
                    MuxDS = MUXD_MDR;
                    pcInc = 1'b1;
                    nextState = S_FETCH;
                end
                S_MEM_WR: begin
                    DtMemWr = 1'b1;
                    pcInc = 1'b1;
                    nextState = S_FETCH;
                end
                S_BRANCH: begin
                    MuxAS = MUXA_REGA;
                    AluOp = ALU_SUB;
                    PcWr = taken;
                    MuxPC = taken ? MUXPC_ALUOUT : MUXPC_ALU;
                    nextState = taken ? S_FETCH : S_PC_INC;
                end
                S_PC_INC: begin
                    pcInc = 1'b1;
                    nextState = S_FETCH;
                end
                S_LUI: begin
                    immtype = IMM_U;
                    MuxDS = MUXD_IMM;
                    BaRegWr = 1'b1;
                    pcInc = 1'b1;
                    nextState = S_FETCH;
                end
                S_JAL1: begin
                    pcInc = 1'b1;
                    nextState = S_JAL2;
                end
                S_JAL2: begin
                    BaRegWr = 1'b1;
                    MuxDS = MUXD_PC;
                    MuxPC = MUXPC_ALUOUT;
                    PcWr = 1'b1;
                    nextState = S_FETCH;
                end
                S_EXC_CAUSE: begin
                    CaseWr = 1'b1;
                    Case_Number = {63'b0, cause};
                    AluOutWr = 1'b1;
                    nextState = S_EXC_EPC;
                end
                S_EXC_EPC: begin
                    EpcWr = 1'b1;
                    MuxDataMem = vecSel;
                    nextState = S_EXC_LATCH;
                end
                S_EXC_LATCH: begin
                    MdrWr = 1'b1;
                    MuxDataMem = vecSel;
                    nextState = S_EXC_JUMP;
                end
                S_EXC_JUMP: begin
                    MuxDS = MUXD_MDR;
                    break_type = BRK_BYTE;
                    MuxPC = MUXPC_EXC;
                    PcWr = 1'b1;
                    nextState = S_FETCH;
                end
                S_HALT:    halted = 1'b1;
                default:   nextState = S_RESET;
            endcase
            if (pcInc) begin
                MuxBS = MUXB_FOUR;
                AluOp = ALU_ADD;
                PcWr = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed per-cycle checks of the control unit output bundle
module tb_control_unit;

    logic        clk, rst, Igual, Overflow;
    logic [31:0] complete_inst;
    logic        PcWr, InRegWr, RegAWr, RegBWr, AluOutWr, MdrWr, DtMemWr, BaRegWr, EpcWr, CaseWr;
    logic        MuxAS, halted;
    logic [1:0]  MuxBS, MuxPC, MuxDataMem, break_type, break_mem_type, ShiftOP;
    logic [2:0]  MuxDS, AluOp, immtype;
    logic [63:0] Case_Number;
    int          checks = 0;
    int          fails = 0;

    control_unit dut (
        .clk(clk), .rst(rst), .complete_inst(complete_inst), .Igual(Igual), .Overflow(Overflow),
        .PcWr(PcWr), .InRegWr(InRegWr), .RegAWr(RegAWr), .RegBWr(RegBWr), .AluOutWr(AluOutWr),
        .MdrWr(MdrWr), .DtMemWr(DtMemWr), .BaRegWr(BaRegWr), .EpcWr(EpcWr), .CaseWr(CaseWr),
        .MuxAS(MuxAS), .MuxBS(MuxBS), .MuxPC(MuxPC), .MuxDS(MuxDS), .MuxDataMem(MuxDataMem),
        .AluOp(AluOp), .immtype(immtype), .break_type(break_type), .break_mem_type(break_mem_type),
        .ShiftOP(ShiftOP), .Case_Number(Case_Number), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [33:0] obs;
    assign obs = {PcWr, InRegWr, RegAWr, RegBWr, AluOutWr, MdrWr, DtMemWr, BaRegWr, EpcWr, CaseWr,
                  MuxAS, MuxBS, MuxPC, MuxDS, MuxDataMem, AluOp, immtype, break_type, break_mem_type,
                  Case_Number[0], |Case_Number[63:1], halted, |ShiftOP};

    function automatic logic [33:0] fx(input logic [9:0] s, input logic a, input logic [1:0] b,
                                       input logic [1:0] p, input logic [2:0] d, input logic [1:0] m,
                                       input logic [2:0] op, input logic [2:0] im, input logic [1:0] bt,
                                       input logic c, input logic h);
        return {s, a, b, p, d, m, op, im, bt, 2'b00, c, 1'b0, h, 1'b0};
    endfunction

    localparam logic [33:0] Z     = '0;
    localparam logic [33:0] E_FE  = fx(10'b0000000000, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_IR  = fx(10'b0100000000, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_DSB = fx(10'b0011100000, 0, 2'b11, 2'b00, 3'b000, 2'b00, 3'b001, 3'b010, 2'b00, 0, 0);
    localparam logic [33:0] E_DUJ = fx(10'b0011100000, 0, 2'b11, 2'b00, 3'b000, 2'b00, 3'b001, 3'b100, 2'b00, 0, 0);
    localparam logic [33:0] E_XAD = fx(10'b0000100000, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b001, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_XSB = fx(10'b0000100000, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b010, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_XAN = fx(10'b0000100000, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b011, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_XI  = fx(10'b0000100000, 1, 2'b10, 2'b00, 3'b000, 2'b00, 3'b001, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_WBA = fx(10'b1000000100, 0, 2'b01, 2'b00, 3'b000, 2'b00, 3'b001, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_ALD = fx(10'b0000100000, 1, 2'b10, 2'b00, 3'b000, 2'b00, 3'b001, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_ASD = fx(10'b0000100000, 1, 2'b10, 2'b00, 3'b000, 2'b00, 3'b001, 3'b001, 2'b00, 0, 0);
    localparam logic [33:0] E_MRD = fx(10'b0000000000, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_MLT = fx(10'b0000010000, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_WBL = fx(10'b1000000100, 0, 2'b01, 2'b00, 3'b010, 2'b00, 3'b001, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_MWR = fx(10'b1000001000, 0, 2'b01, 2'b00, 3'b000, 2'b00, 3'b001, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_BRT = fx(10'b1000000000, 1, 2'b00, 2'b01, 3'b000, 2'b00, 3'b010, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_BRN = fx(10'b0000000000, 1, 2'b00, 2'b00, 3'b000, 2'b00, 3'b010, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_PCI = fx(10'b1000000000, 0, 2'b01, 2'b00, 3'b000, 2'b00, 3'b001, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_LUI = fx(10'b1000000100, 0, 2'b01, 2'b00, 3'b001, 2'b00, 3'b001, 3'b011, 2'b00, 0, 0);
    localparam logic [33:0] E_JL2 = fx(10'b1000000100, 0, 2'b00, 2'b01, 3'b101, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_EC0 = fx(10'b0000100001, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_EC1 = fx(10'b0000100001, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 3'b000, 2'b00, 1, 0);
    localparam logic [33:0] E_EP0 = fx(10'b0000000010, 0, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_EP1 = fx(10'b0000000010, 0, 2'b00, 2'b00, 3'b000, 2'b10, 3'b000, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_EL0 = fx(10'b0000010000, 0, 2'b00, 2'b00, 3'b000, 2'b01, 3'b000, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_EL1 = fx(10'b0000010000, 0, 2'b00, 2'b00, 3'b000, 2'b10, 3'b000, 3'b000, 2'b00, 0, 0);
    localparam logic [33:0] E_EJ  = fx(10'b1000000000, 0, 2'b00, 2'b10, 3'b010, 2'b00, 3'b000, 3'b000, 2'b11, 0, 0);
    localparam logic [33:0] E_HLT = fx(10'b0000000000, 0, 2'b00, 2'b00, 3'b000, 2'b00, 3'b000, 3'b000, 2'b00, 0, 1);

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_BADR = 32'h4020F1B3;
    localparam logic [31:0] I_ADDI = 32'h00108093;
    localparam logic [31:0] I_LD   = 32'h0080B283;
    localparam logic [31:0] I_SD   = 32'h0050F423;
    localparam logic [31:0] I_BEQ  = 32'h00208063;
    localparam logic [31:0] I_BNE  = 32'h00209063;
    localparam logic [31:0] I_LUI  = 32'h000012B7;
    localparam logic [31:0] I_JAL  = 32'h0080006F;
    localparam logic [31:0] I_EBRK = 32'h00100073;
    localparam logic [31:0] I_INV  = 32'h0000007F;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // cycle c of the instruction (c=1 is FETCH) is expected to show exp[8-c]
    task automatic runInst(input string name, input logic [31:0] inst, input logic ig, input logic ov,
                           input int n, input logic [7:0][33:0] exp);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c == 0) begin
                complete_inst = inst;
                Igual = ig;
                Overflow = ov;
            end
            checkVal($sformatf("%s.c%0d", name, c + 1), {30'b0, obs}, {30'b0, exp[7 - c]});
        end
    endtask

    task automatic holdReset(input string name);
        rst = 1'b1;
        #1 checkVal({name, ".now"}, {30'b0, obs}, {30'b0, E_FE});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkVal($sformatf("%s.r%0d", name, k), {30'b0, obs}, {30'b0, E_FE});
        end
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        Igual = 1'b0;
        Overflow = 1'b0;
        complete_inst = '0;
        holdReset("reset");
        runInst("add",    I_ADD,  0, 0, 5, {E_FE, E_IR, E_DSB, E_XAD, E_WBA, Z, Z, Z});
        runInst("sub",    I_SUB,  0, 0, 5, {E_FE, E_IR, E_DSB, E_XSB, E_WBA, Z, Z, Z});
        runInst("andovf", I_AND,  0, 1, 5, {E_FE, E_IR, E_DSB, E_XAN, E_WBA, Z, Z, Z});
        runInst("addi",   I_ADDI, 0, 0, 5, {E_FE, E_IR, E_DSB, E_XI,  E_WBA, Z, Z, Z});
        runInst("addovf", I_ADD,  0, 1, 8, {E_FE, E_IR, E_DSB, E_XAD, E_EC1, E_EP1, E_EL1, E_EJ});
        runInst("inv",    I_INV,  0, 0, 7, {E_FE, E_IR, E_DSB, E_EC0, E_EP0, E_EL0, E_EJ, Z});
        runInst("badr",   I_BADR, 0, 0, 7, {E_FE, E_IR, E_DSB, E_EC0, E_EP0, E_EL0, E_EJ, Z});
        runInst("beqT",   I_BEQ,  1, 0, 4, {E_FE, E_IR, E_DSB, E_BRT, Z, Z, Z, Z});
        runInst("beqN",   I_BEQ,  0, 0, 5, {E_FE, E_IR, E_DSB, E_BRN, E_PCI, Z, Z, Z});
        runInst("bneT",   I_BNE,  0, 0, 4, {E_FE, E_IR, E_DSB, E_BRT, Z, Z, Z, Z});
        runInst("bneN",   I_BNE,  1, 0, 5, {E_FE, E_IR, E_DSB, E_BRN, E_PCI, Z, Z, Z});
        runInst("lui",    I_LUI,  0, 0, 4, {E_FE, E_IR, E_DSB, E_LUI, Z, Z, Z, Z});
        runInst("jal",    I_JAL,  0, 0, 5, {E_FE, E_IR, E_DUJ, E_PCI, E_JL2, Z, Z, Z});
        runInst("ldcut",  I_LD,   0, 0, 5, {E_FE, E_IR, E_DSB, E_ALD, E_MRD, Z, Z, Z});
        holdReset("rstld");
        runInst("addrst", I_ADD,  0, 0, 5, {E_FE, E_IR, E_DSB, E_XAD, E_WBA, Z, Z, Z});
        runInst("ld",     I_LD,   0, 0, 7, {E_FE, E_IR, E_DSB, E_ALD, E_MRD, E_MLT, E_WBL, Z});
        runInst("sd",     I_SD,   0, 0, 5, {E_FE, E_IR, E_DSB, E_ASD, E_MWR, Z, Z, Z});
        runInst("ebreak", I_EBRK, 0, 0, 4, {E_FE, E_IR, E_DSB, E_HLT, Z, Z, Z, Z});
        complete_inst = I_ADD;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            checkVal($sformatf("halt.h%0d", k), {30'b0, obs}, {30'b0, E_HLT});
        end
        holdReset("rsthalt");
        runInst("addend", I_ADD,  0, 0, 5, {E_FE, E_IR, E_DSB, E_XAD, E_WBA, Z, Z, Z});
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle sequencer for the 64-bit RISC-V datapath. Decodes the latched instruction and drives every write enable, mux select, ALU op, immediate type and exception strobe, one state per cycle. Supported: add, sub, and, addi, ld, sd, beq, bne, lui, jal and ebreak. Invalid opcodes and ALU overflow trap through EPC/Causa and a vector byte read from data memory.

## Interface
- No parameters. Encodings are fixed in `control_pkg`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high.
- `complete_inst` in 32: IR contents. Fields used: opcode [6:0], funct3 [14:12], funct7 [31:25].
- `Igual`, `Overflow` in 1 each: ALU flags, combinational in the current cycle.
- `PcWr`, `InRegWr`, `RegAWr`, `RegBWr`, `AluOutWr`, `MdrWr`, `DtMemWr`, `BaRegWr`, `EpcWr`, `CaseWr` out 1 each: write strobes.
- `MuxAS` out 1: 0 = PC, 1 = RegA.
- `MuxBS` out 2: 00 = RegB, 01 = const 4, 10 = imm, 11 = imm<<1.
- `MuxPC` out 2: 00 = ALU result, 01 = AluOut, 10 = exception byte.
- `MuxDS` out 3: 000 = AluOut, 001 = imm, 010 = MDR, 101 = PC.
- `MuxDataMem` out 2: 00 = AluOut, 01 = 254, 10 = 255.
- `AluOp` out 3: 000 = pass A, 001 = add, 010 = sub, 011 = and.
- `immtype` out 3: 000 = I, 001 = S, 010 = SB, 011 = U, 100 = UJ.
- `break_type`, `break_mem_type` out 2 each: 00 = 64-bit pass, 11 = zero-extended byte.
- `ShiftOP` out 2: tied to 00.
- `Case_Number` out 64: 0 = invalid opcode, 1 = overflow.
- `halted` out 1: high in HALT.

## Operation
- Unlisted outputs are 0 in every state. `Case_Number` is 0 except while CaseWr is asserted.
- **RESET**: all outputs 0. Goes to FETCH.
- **FETCH**: instruction memory read wait; no strobes.
- **IR_LOAD**: InRegWr.
- **DECODE**
  - RegAWr and RegBWr.
  - AluOut ← PC + (imm<<1): MuxAS=0, MuxBS=11, AluOp=001, AluOutWr.
  - immtype = UJ for jal, SB otherwise.
  - Branches on opcode class.
- **Opcode classes**
  - R 0110011: add f3=000/f7=0000000, sub f3=000/f7=0100000, and f3=111/f7=0000000.
  - addi 0010011/000; ld 0000011/011; sd 0100011/111.
  - beq 1100011/000, bne 1100011/001; lui 0110111; jal 1101111; ebreak 1110011.
  - Anything else → EXC_CAUSE with cause 0.
- **EXEC_R / EXEC_I**
  - MuxAS=1, AluOutWr; MuxBS=00 (R) or 10 with immtype I (addi).
  - If Overflow during add/sub → EXC_CAUSE with cause 1, else WB_ALU.
- **WB_ALU**: BaRegWr, MuxDS=000. Same cycle PC ← PC+4 (MuxAS=0, MuxBS=01, AluOp=001, MuxPC=00, PcWr). All "PC+4" below use this encoding.
- **ADDR**: AluOut ← RegA + imm; immtype I for ld, S for sd. Next MEM_RD (ld) or MEM_WR (sd).
- **MEM_RD**: MuxDataMem=00, wait. **MEM_LATCH**: MdrWr. **WB_LD**: BaRegWr, MuxDS=010, break_type=00, PC+4.
- **MEM_WR**: DtMemWr, break_mem_type=00, PC+4.
- **BRANCH**
  - AluOp=010, MuxAS=1, MuxBS=00.
  - Taken (beq & Igual, or bne & !Igual) → MuxPC=01, PcWr, then FETCH.
  - Not taken → PC_INC (PC+4).
- **LUI**: immtype U, MuxDS=001, BaRegWr, PC+4.
- **JAL1**: PC+4. **JAL2**: BaRegWr, MuxDS=101, MuxPC=01, PcWr.
- **EXC_CAUSE**: CaseWr with the cause; AluOut ← PC (AluOp=000, MuxAS=0, AluOutWr).
- **EXC_EPC**: EpcWr; MuxDataMem = 01 for cause 0, 10 for cause 1.
- **EXC_LATCH**: same MuxDataMem; MdrWr.
- **EXC_JUMP**: MuxDS=010, break_type=11, MuxPC=10, PcWr.
- **HALT**: ebreak target. `halted`=1, no strobes, leaves only on rst.
- Every terminal state returns to FETCH. The cause is held in a 1-bit internal register.

## Timing
- Reset
  - rst high at an edge → RESET on that edge, from any state.
  - Outputs are forced to 0 combinationally while rst is high, so no strobe fires in a cycle where rst is sampled.
  - First FETCH follows the first edge with rst low.
- Cycles per instruction, FETCH to next FETCH:
  - R/addi 5, ld 7, sd 5, lui 4, jal 5.
  - Branch taken 4, not taken 5.
  - Exception: detection state + 4.
- Overflow is sampled only in EXEC_R/EXEC_I for add/sub. `and` never traps. On a trap, BaRegWr is never asserted for that instruction.
- Exactly one state per cycle, Moore outputs, except the branch and overflow decisions, which are Mealy on the ALU flags.

## Structure
- `control_pkg`: `state_t` enum, opcode/funct constants, mux/AluOp/immtype encodings, cause values.
- One sub-module, `control_decode`: combinational complete_inst → opcode class enum plus valid flag.
- Top level: state register, cause register, next-state logic, output decode.

## Test plan
- Reset held 3 cycles mid-LD (state MEM_RD) → all strobes 0, next state FETCH, no MdrWr or BaRegWr.
- add x3,x1,x2 → InRegWr at cycle 2, AluOutWr at cycle 4, BaRegWr with PcWr (MuxPC=00) at cycle 5, then FETCH.
- add with Overflow=1 in EXEC_R → no BaRegWr; CaseWr with Case_Number=1; EpcWr; MuxDataMem=10; PcWr with MuxPC=10 four cycles after EXEC.
- Opcode 1111111 → EXC_CAUSE with Case_Number=0, MuxDataMem=01 in EXC_EPC/EXC_LATCH.
- beq with Igual=1 → PcWr, MuxPC=01 in cycle 4. With Igual=0 → PC_INC in cycle 5. bne is the mirror.
- ld then sd then ebreak → 7-cycle ld (MdrWr in cycle 6), DtMemWr in sd cycle 5, `halted` stays 1 for 10+ cycles until rst.
